// File: rtl/weight_fetch_ctrl.sv
// Weight-tile fetch sequencer: issues SRAM reads, buffers data in a 2-entry FIFO, streams it out.
// Optional stall counter enabled by defining WEIGHT_FETCH_STALL_CNT_EN.
module weight_fetch_ctrl #(
  parameter int unsigned MEM_BW      = 128,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   arst_n_in,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] num_words,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_re,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [MEM_BW-1:0]      mem_rdata,
  output logic                   weights_valid,
  input  logic                   weights_ready,
  output logic [MEM_BW-1:0]      weights_data
`ifdef WEIGHT_FETCH_STALL_CNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   outst_q;
  logic [MEM_BW-1:0]      fifo_q [2];
  logic                   rd_ptr_q, wr_ptr_q;
  logic [1:0]             occ_q, occ_d;
  logic                   push, pop, start_ok;
  logic [2:0]             inflight;

  assign start_ok      = (state_q == StIdle) && start;
  assign push          = outst_q;
  assign weights_valid = (occ_q != 2'd0);
  assign pop           = weights_valid && weights_ready;
  assign weights_data  = fifo_q[rd_ptr_q];
  assign mem_addr      = addr_q;
  assign occ_d         = occ_q + {1'b0, push} - {1'b0, pop};
  // Words held or in flight after this cycle's pop; a pop this cycle frees a slot immediately.
  assign inflight      = {1'b0, occ_q} + {2'b0, outst_q} - {2'b0, pop};

  // State register
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (num_words == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (mem_re && (cnt_q == COUNT_WIDTH'(1))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // A pending return would make occ_d non-zero, so this also covers outstanding reads.
        if (occ_d == 2'd0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy   = (state_q == StFetch) || (state_q == StDrain);
    done   = (state_q == StDone);
    mem_re = (state_q == StFetch) && (inflight < 3'd2);
  end

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (start_ok) begin
      addr_d = base_addr;
      cnt_d  = num_words;
    end else if (mem_re) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      cnt_d  = cnt_q - COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      outst_q   <= 1'b0;
      occ_q     <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      outst_q <= mem_re;
      occ_q   <= occ_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

`ifdef WEIGHT_FETCH_STALL_CNT_EN
  logic [COUNT_WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_ok) begin
      stall_d = '0;
    end else if (weights_valid && !weights_ready && (stall_q != '1)) begin
      stall_d = stall_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
